// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - raster-to-column line buffer producing 3-row pixel columns
//
// Purpose: accepts one pixel per clock in raster order, keeps the two previous
// lines in column-addressed memories and emits, one clock later, the column
// (row r, r-1, r-2) at the accepted pixel's coordinates.
// Optional feature macro: LINEBUF_BORDER_REPLICATE_EN. When it is defined, rows 0
// and 1 are emitted with the missing rows replicated. When it is undefined,
// rows 0 and 1 are suppressed.
//
// Ports:
//   iclk    in   clock, rising edge
//   irst    in   synchronous active-high reset; wins over ivalid in the same cycle
//   ivalid  in   input pixel strobe
//   isof    in   start of frame, qualified by ivalid; forces the pixel to (0,0)
//   idata   in   input pixel
//   ovalid  out  output column valid
//   odata0  out  pixel (r, c)
//   odata1  out  pixel (r-1, c)
//   odata2  out  pixel (r-2, c)
//   ocol    out  column c of the output
//   orow    out  row r of the output
//   oeof    out  high with the output for (IMG_H-1, IMG_W-1)
module line_buffer_3row #(
  parameter int DATA_W = 9,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CW     = $clog2(IMG_W),
  parameter int RW     = $clog2(IMG_H)
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ivalid,
  input  logic              isof,
  input  logic [DATA_W-1:0] idata,
  output logic              ovalid,
  output logic [DATA_W-1:0] odata0,
  output logic [DATA_W-1:0] odata1,
  output logic [DATA_W-1:0] odata2,
  output logic [CW-1:0]     ocol,
  output logic [RW-1:0]     orow,
  output logic              oeof
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [DATA_W-1:0] mem1_q [IMG_W];  // row r-1
  logic [DATA_W-1:0] mem2_q [IMG_W];  // row r-2

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              ovalid_q, ovalid_d;
  logic              oeof_q, oeof_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [CW-1:0]     ocol_q, ocol_d;
  logic [RW-1:0]     orow_q, orow_d;

  logic              accept;
  logic [CW-1:0]     pix_col;
  logic [RW-1:0]     pix_row;
  logic [DATA_W-1:0] rd1, rd2;

  // A pixel that arrives during reset is dropped, including its memory write.
  assign accept  = ivalid && !irst;
  assign pix_col = isof ? '0 : col_q;
  assign pix_row = isof ? '0 : row_q;
  assign rd1     = mem1_q[pix_col];
  assign rd2     = mem2_q[pix_col];

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    ocol_d   = ocol_q;
    orow_d   = orow_q;
    ovalid_d = 1'b0;
    oeof_d   = 1'b0;
    if (ivalid) begin
`ifdef LINEBUF_BORDER_REPLICATE_EN
      ovalid_d = 1'b1;
      if (pix_row == '0) begin
        d1_d = idata;
        d2_d = idata;
      end else if (pix_row == RW'(1)) begin
        d1_d = rd1;
        d2_d = rd1;
      end else begin
        d1_d = rd1;
        d2_d = rd2;
      end
`else
      ovalid_d = (pix_row >= RW'(2));
      d1_d     = rd1;
      d2_d     = rd2;
`endif
      oeof_d = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
      d0_d   = idata;
      ocol_d = pix_col;
      orow_d = pix_row;
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
      end else begin
        col_d = pix_col + CW'(1);
        row_d = pix_row;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      col_q    <= '0;
      row_q    <= '0;
      ovalid_q <= 1'b0;
      oeof_q   <= 1'b0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      ocol_q   <= '0;
      orow_q   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      ovalid_q <= ovalid_d;
      oeof_q   <= oeof_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      ocol_q   <= ocol_d;
      orow_q   <= orow_d;
    end
  end

  // Line memories are never reset; stale lines are masked by the row check.
  always_ff @(posedge iclk) begin
    if (accept) begin
      mem2_q[pix_col] <= rd1;
      mem1_q[pix_col] <= idata;
    end
  end

  assign ovalid = ovalid_q;
  assign oeof   = oeof_q;
  assign odata0 = d0_q;
  assign odata1 = d1_q;
  assign odata2 = d2_q;
  assign ocol   = ocol_q;
  assign orow   = orow_q;

endmodule

// File: doc/line_buffer_3row.md
# line_buffer_3row

Raster-to-column line buffer for the SIFT detection front end. It accepts one pixel per cycle in raster order and stores the two previous image lines. For each pixel it emits a vertically aligned column of three pixels: current row, row-1 and row-2. The three outputs feed three horizontal 3-tap window registers, which together form the 3×3 neighbourhood used by the detection stages.

## Interface
- DATA_W, 9, pixel width in bits
- IMG_W, 640, pixels per line (≥ 3)
- IMG_H, 480, lines per frame (≥ 3)
- CW, $clog2(IMG_W), column counter width (derived)
- RW, $clog2(IMG_H), row counter width (derived)

- iclk  in  1  clock; all logic on rising edge
- irst  in  1  synchronous, active-high reset
- ivalid  in  1  input pixel strobe; one pixel accepted per cycle when high
- isof  in  1  start of frame; qualified by ivalid; marks the pixel at row 0, column 0
- idata  in  DATA_W  input pixel
- ovalid  out  1  output column valid
- odata0  out  DATA_W  pixel at (row r, col c)
- odata1  out  DATA_W  pixel at (r-1, c)
- odata2  out  DATA_W  pixel at (r-2, c)
- ocol  out  CW  column c of the current output
- orow  out  RW  row r of the current output
- oeof  out  1  high with the output for (IMG_H-1, IMG_W-1)

## Operation
- Two line memories, each IMG_W × DATA_W, addressed by column:
  - mem1 holds row r-1.
  - mem2 holds row r-2.
- On an accepted pixel (ivalid=1) at column c, within one clock:
  - Read mem1[c] and mem2[c] (read-before-write).
  - Write mem2[c] ← old mem1[c].
  - Write mem1[c] ← idata.
- Output registers are loaded on the same edge: odata0 ← idata, odata1 ← old mem1[c], odata2 ← old mem2[c]; ocol/orow ← the accepted pixel's coordinates.
- Column/row counters:
  - col increments per accepted pixel and wraps IMG_W-1 → 0, incrementing row.
  - row wraps IMG_H-1 → 0 on the last pixel of the frame.
- isof with ivalid: the pixel is treated as (0,0) regardless of counter state. Counters then continue from (0,1).
- isof without ivalid: ignored.
- ivalid low: counters, memories and data outputs hold; ovalid=0 and oeof=0 the following cycle.
- Without border replication, ovalid = accepted pixel and row ≥ 2.
- oeof is high only for one valid output, at coordinates (IMG_H-1, IMG_W-1).
- No backpressure. The downstream stage accepts every ovalid cycle.

## Timing
- Latency: 1 clock from ivalid/idata to ovalid/odata*. Throughput: 1 pixel/clock.
- Reset (irst=1 at an edge):
  - ovalid=0, oeof=0, odata0/1/2=0, ocol=0, orow=0.
  - Counters cleared to (0,0).
  - Memory contents are not cleared.
- Reset mid-frame: the next accepted pixel is (0,0). Stale memory is never presented with ovalid=1 because row < 2 (or because it is replicated, see Configuration).
- irst has priority over ivalid in the same cycle; that pixel is dropped.
- isof mid-line: the partial line is abandoned. Rows 0–1 of the new frame suppress or replicate as usual.

## Configuration
- LINEBUF_BORDER_REPLICATE_EN defined:
  - ovalid is asserted for every accepted pixel, including rows 0 and 1.
  - Row 0: odata1 = odata2 = idata.
  - Row 1: odata1 = odata2 = old mem1[c] (row 0 replicated).
  - Rows ≥ 2 are unchanged.
- LINEBUF_BORDER_REPLICATE_EN undefined: ovalid is suppressed for rows 0 and 1. The first valid output per frame is (2,0).

## Test plan
Bench parameters: IMG_W=4, IMG_H=4, DATA_W=9, macro undefined unless stated. Pixel value = 16·row + col.
- Reset, then stream a full frame continuously (isof on the first pixel) -> ovalid first high 1 cycle after pixel (2,0) with odata0=32, odata1=16, odata2=0. At (3,3): odata0=51, odata1=35, odata2=19, oeof=1.
- Same frame with ivalid deasserted every other cycle -> identical output sequence; ovalid never high in two consecutive cycles; counters unaffected by the gaps.
- Assert irst at pixel (2,1), then restart the frame with isof -> outputs 0 the cycle after reset; first ovalid at the new (2,0), with data from the new frame only.
- Assert isof at pixel (1,2) of a frame -> that pixel is reported as (0,0); the next pixel as (0,1); no ovalid until new row 2.
- With LINEBUF_BORDER_REPLICATE_EN, stream a frame -> ovalid from pixel (0,0) with odata0=odata1=odata2=0. At (1,3): odata0=19, odata1=odata2=3.
- Back-to-back frames with no gap -> the second frame's (2,0) output is odata0=32, odata1=16, odata2=0; no first-frame data leaks through.
